// File: rtl/preg_ready_table.sv
// preg_ready_table: ready-bit table for the physical register file of the
// out-of-order core. Rename allocation clears a tag's ready bit, either
// writeback port sets it, and a flush forces every tag ready. It also keeps
// a registered count of not-ready tags and a sticky protocol-error flag.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   flush          misprediction recovery, forces all tags ready
//   alloc_valid    rename allocated alloc_tag this cycle
//   alloc_tag      tag to mark not-ready
//   wb0_valid/tag  writeback port 0, tag to mark ready
//   wb1_valid/tag  writeback port 1, tag to mark ready
//   ready_vec      registered ready bits, bit i = tag i ready
//   ready_vec_byp  combinational ready_vec | wb0 one-hot | wb1 one-hot
//   pending_count  registered number of zero bits in ready_vec
//   proto_err      sticky protocol-violation flag
module preg_ready_table #(
  parameter int unsigned NUM_TAGS = 16,
  parameter int unsigned TAG_W    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                alloc_valid,
  input  logic [TAG_W-1:0]    alloc_tag,
  input  logic                wb0_valid,
  input  logic [TAG_W-1:0]    wb0_tag,
  input  logic                wb1_valid,
  input  logic [TAG_W-1:0]    wb1_tag,
  output logic [NUM_TAGS-1:0] ready_vec,
  output logic [NUM_TAGS-1:0] ready_vec_byp,
  output logic [TAG_W:0]      pending_count,
  output logic                proto_err
);

  localparam int unsigned CNT_W = TAG_W + 1;

  logic [NUM_TAGS-1:0] ready_q, ready_d;
  logic [CNT_W-1:0]    pend_q, pend_d;
  logic                err_q, err_d;

  logic [NUM_TAGS-1:0] wb0_oh, wb1_oh, set_mask, clr_mask;
  logic                err_dbl_alloc, err_spur0, err_spur1, err_dup_wb;
  logic                err_alloc_wb, err_any;

  // One-hot decodes of each port, gated by its valid.
  always_comb begin
    wb0_oh   = '0;
    wb1_oh   = '0;
    clr_mask = '0;
    if (wb0_valid)   wb0_oh   = NUM_TAGS'(1) << wb0_tag;
    if (wb1_valid)   wb1_oh   = NUM_TAGS'(1) << wb1_tag;
    if (alloc_valid) clr_mask = NUM_TAGS'(1) << alloc_tag;
    set_mask = wb0_oh | wb1_oh;
  end

  // Same-cycle wakeup path for the issue-side tag-lookup muxes; still ORs the
  // writeback bits during flush since issue is ignored then anyway.
  always_comb begin
    ready_vec_byp = ready_q | set_mask;
  end

  // Protocol checks, all against the registered (pre-update) state.
  always_comb begin
    err_dbl_alloc = alloc_valid && !ready_q[alloc_tag];
    err_spur0     = wb0_valid && ready_q[wb0_tag];
    err_spur1     = wb1_valid && ready_q[wb1_tag];
    err_dup_wb    = wb0_valid && wb1_valid && (wb0_tag == wb1_tag);
    err_alloc_wb  = alloc_valid &&
                    ((wb0_valid && (wb0_tag == alloc_tag)) ||
                     (wb1_valid && (wb1_tag == alloc_tag)));
    err_any       = err_dbl_alloc | err_spur0 | err_spur1 |
                    err_dup_wb | err_alloc_wb;
  end

  // Next state: flush dominates; otherwise clear wins over set on a tag.
  always_comb begin
    ready_d = ready_q;
    err_d   = err_q;
    if (flush) begin
      ready_d = '1;
    end else begin
      ready_d = (ready_q | set_mask) & ~clr_mask;
      if (err_any) err_d = 1'b1;
    end
  end

  // Pending count tracks the next ready vector so both land on one edge.
  always_comb begin
    pend_d = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (!ready_d[i]) pend_d = pend_d + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= '1;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign ready_vec     = ready_q;
  assign pending_count = pend_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_preg_ready_table.sv
// Directed bench for preg_ready_table with an expected-state scoreboard.
module tb_preg_ready_table;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        alloc_valid;
  logic [3:0]  alloc_tag;
  logic        wb0_valid;
  logic [3:0]  wb0_tag;
  logic        wb1_valid;
  logic [3:0]  wb1_tag;
  logic [15:0] ready_vec;
  logic [15:0] ready_vec_byp;
  logic [4:0]  pending_count;
  logic        proto_err;

  preg_ready_table dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .alloc_valid   (alloc_valid),
    .alloc_tag     (alloc_tag),
    .wb0_valid     (wb0_valid),
    .wb0_tag       (wb0_tag),
    .wb1_valid     (wb1_valid),
    .wb1_tag       (wb1_tag),
    .ready_vec     (ready_vec),
    .ready_vec_byp (ready_vec_byp),
    .pending_count (pending_count),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rv;
    logic [4:0]  pc;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_ready;
  logic        m_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check the bypass vector, push expected state.
  task automatic drive(input logic fl, input logic av, input logic [3:0] at,
                       input logic w0v, input logic [3:0] w0t,
                       input logic w1v, input logic [3:0] w1t);
    logic [15:0] s, c, nxt, oh;
    logic        e;
    exp_t        x;
    flush = fl; alloc_valid = av; alloc_tag = at;
    wb0_valid = w0v; wb0_tag = w0t; wb1_valid = w1v; wb1_tag = w1t;
    s = 16'h0; c = 16'h0;
    if (w0v) begin oh = 16'h1; s = s | (oh << w0t); end
    if (w1v) begin oh = 16'h1; s = s | (oh << w1t); end
    if (av)  begin oh = 16'h1; c = oh << at; end
    #1;
    chk("byp", 32'(ready_vec_byp), 32'(m_ready | s));
    e = m_err;
    if (fl) nxt = 16'hFFFF;
    else begin
      nxt = (m_ready | s) & ~c;
      if (av && !m_ready[at]) e = 1'b1;
      if (w0v && m_ready[w0t]) e = 1'b1;
      if (w1v && m_ready[w1t]) e = 1'b1;
      if (w0v && w1v && w0t == w1t) e = 1'b1;
      if (av && ((w0v && w0t == at) || (w1v && w1t == at))) e = 1'b1;
    end
    x.rv = nxt; x.pc = 5'($countones(~nxt)); x.err = e;
    sb.push_back(x);
  endtask

  // Clock the cycle, pop and compare, then return inputs to idle.
  task automatic finish_cycle();
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      x = sb.pop_front();
      chk("ready_vec", 32'(ready_vec), 32'(x.rv));
      chk("pending_count", 32'(pending_count), 32'(x.pc));
      chk("proto_err", 32'(proto_err), 32'(x.err));
      m_ready = x.rv;
      m_err   = x.err;
    end
    @(negedge clk);
    flush = 1'b0; alloc_valid = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
  endtask

  task automatic cyc(input logic fl, input logic av, input logic [3:0] at,
                     input logic w0v, input logic [3:0] w0t,
                     input logic w1v, input logic [3:0] w1t);
    drive(fl, av, at, w0v, w0t, w1v, w1t);
    finish_cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_vec), 32'h0000FFFF);
    chk("rst_pend", 32'(pending_count), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
    m_ready = 16'hFFFF;
    m_err   = 1'b0;
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_tag = '0;
    wb0_valid = 1'b0; wb0_tag = '0; wb1_valid = 1'b0; wb1_tag = '0;
    m_ready = 16'hFFFF; m_err = 1'b0;
    @(negedge clk);
    do_reset();

    // Alloc 3, 7, 15 then writeback 7.
    cyc(1'b0, 1'b1, 4'd3,  1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd7,  1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("alloc3_ready", 32'(ready_vec), 32'h00007F77);
    chk("alloc3_pend", 32'(pending_count), 32'd3);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0);
    chk("wb7_byp", 32'(ready_vec_byp), 32'h00007FF7);
    finish_cycle();
    chk("wb7_ready", 32'(ready_vec), 32'h00007FF7);
    chk("wb7_pend", 32'(pending_count), 32'd2);
    chk("wb7_err", 32'(proto_err), 32'd0);

    // Bring tag 15 back so alloc 0 yields FFF6, then dual wb + alloc.
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd15);
    cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("pre_dual_ready", 32'(ready_vec), 32'h0000FFF6);
    cyc(1'b0, 1'b1, 4'd9, 1'b1, 4'd0, 1'b1, 4'd3);
    chk("dual_ready", 32'(ready_vec), 32'h0000FDFF);
    chk("dual_pend", 32'(pending_count), 32'd1);
    chk("dual_err", 32'(proto_err), 32'd0);

    // Conflict: alloc and wb on tag 5 while tag 5 is not ready.
    cyc(1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 1'b0, 4'd0);
    chk("conf_bit5", 32'(ready_vec[5]), 32'd0);
    chk("conf_err", 32'(proto_err), 32'd1);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("sticky_err", 32'(proto_err), 32'd1);

    // Async reset mid-run after a few allocs, held across an edge.
    cyc(1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_ready", 32'(ready_vec), 32'h0000FFFF);
    chk("async_pend", 32'(pending_count), 32'd0);
    chk("async_err", 32'(proto_err), 32'd0);
    alloc_valid = 1'b1; alloc_tag = 4'd6;
    @(posedge clk);
    #1;
    chk("hold_ready", 32'(ready_vec), 32'h0000FFFF);
    alloc_valid = 1'b0;
    m_ready = 16'hFFFF; m_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("post_rst_ready", 32'(ready_vec), 32'h0000FFBF);

    // Allocate everything, then flush with alloc and a duplicate wb.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 4'(i), 1'b0, 4'd0, 1'b0, 4'd0);
    chk("full_pend", 32'(pending_count), 32'd16);
    chk("full_ready", 32'(ready_vec), 32'h00000000);
    drive(1'b1, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 4'd4);
    chk("flush_byp", 32'(ready_vec_byp), 32'h00000010);
    finish_cycle();
    chk("flush_ready", 32'(ready_vec), 32'h0000FFFF);
    chk("flush_pend", 32'(pending_count), 32'd0);
    chk("flush_err", 32'(proto_err), 32'd0);

    // Spurious wakeup on an already-ready tag 12.
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd12);
    chk("spur_err", 32'(proto_err), 32'd1);
    chk("spur_ready", 32'(ready_vec), 32'h0000FFFF);

    // Double allocation of tag 4 from reset.
    do_reset();
    cyc(1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("dbl1_err", 32'(proto_err), 32'd0);
    cyc(1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("dbl2_err", 32'(proto_err), 32'd1);
    chk("dbl2_ready", 32'(ready_vec), 32'h0000FFEF);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
